// File: rtl/ac_cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcode field values, default
// bus widths and the fetch/memory-interface FSM state encoding.
package ac_cpu_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_WORD_W = 8;

  // Opcodes are decoded from upcode[3:1]
  localparam logic [2:0] OP_LDA = 3'b000;
  localparam logic [2:0] OP_STA = 3'b001;
  localparam logic [2:0] OP_ADA = 3'b010;
  localparam logic [2:0] OP_ANA = 3'b011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ABORT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_watchdog.sv
// Ack watchdog for the fetch bus: counts cycles spent waiting in REQ and
// raises a sticky bus error when TIMEOUT_CYC cycles pass without an ack.
module fetch_watchdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  input  logic ack,
  output logic timeout,
  output logic bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  // Fires on the last waiting cycle so mem_req is high exactly TIMEOUT_CYC cycles
  assign timeout = run && !ack && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      bus_err <= 1'b0;
    end else begin
      if (clear)
        cnt <= '0;
      else if (run && !ack)
        cnt <= cnt + CW'(1);
      if (timeout)
        bus_err <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_mem_if.sv
// Instruction-fetch / memory-interface stage: owns PC and the two-word IR and
// turns memRead/memWrite strobes into a req/ack bus transaction.
// Optional ack watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_mem_if
  import ac_cpu_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WORD_W      = DEF_WORD_W,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pcWrite,
  input  logic              irWrite,
  input  logic              IRwriteSel,
  input  logic              memAddressSel,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [WORD_W-1:0] ac_data,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [3:0]        upcode,
  output logic [ADDR_W-1:0] operand_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              bus_err
);

  localparam int OPW = WORD_W + 4;

  fetch_state_t      state, state_nxt;
  logic              accept, complete, timeout;
  logic              cmd_we, cmd_pcw, cmd_irw, cmd_irsel;
  logic [ADDR_W-1:0] cmd_addr;
  logic [WORD_W-1:0] cmd_wdata;
  logic [WORD_W-1:0] ir0, ir1;
  logic [OPW-1:0]    opnd_full;

  assign accept   = (state == ST_IDLE) && (memRead || memWrite);
  assign complete = (state == ST_REQ) && mem_ack;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (memRead || memWrite) state_nxt = ST_REQ;
      ST_REQ: begin
        if (mem_ack)      state_nxt = ST_IDLE;
        else if (timeout) state_nxt = ST_ABORT;
      end
      ST_ABORT: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Command latch: write wins over a simultaneous read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_we    <= 1'b0;
      cmd_pcw   <= 1'b0;
      cmd_irw   <= 1'b0;
      cmd_irsel <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
    end else if (accept) begin
      cmd_we    <= memWrite;
      cmd_pcw   <= pcWrite;
      cmd_irw   <= irWrite;
      cmd_irsel <= IRwriteSel;
      cmd_addr  <= memAddressSel ? operand_addr : pc;
      cmd_wdata <= ac_data;
    end
  end

  // Read completion updates rd_data, IR and PC
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc       <= '0;
      ir0      <= '0;
      ir1      <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (complete && !cmd_we) begin
        rd_data  <= mem_rdata;
        rd_valid <= 1'b1;
        if (cmd_irw) begin
          if (cmd_irsel) ir1 <= mem_rdata;
          else           ir0 <= mem_rdata;
        end
        if (cmd_pcw)
          pc <= pc + ADDR_W'(1);
      end
    end
  end

  assign mem_req   = (state == ST_REQ);
  assign mem_we    = (state == ST_REQ) && cmd_we;
  assign mem_addr  = cmd_addr;
  assign mem_wdata = cmd_wdata;
  assign busy      = (state != ST_IDLE);
  assign upcode    = ir0[WORD_W-1 -: 4];
  assign opnd_full = {ir0[3:0], ir1};

  generate
    if (ADDR_W > OPW) begin : g_opnd_ext
      assign operand_addr = {{(ADDR_W-OPW){1'b0}}, opnd_full};
    end else if (ADDR_W == OPW) begin : g_opnd_eq
      assign operand_addr = opnd_full;
    end else begin : g_opnd_trunc
      assign operand_addr = opnd_full[ADDR_W-1:0];
    end
  endgenerate

`ifdef FETCH_TIMEOUT_EN
  fetch_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .run     (state == ST_REQ),
    .ack     (mem_ack),
    .timeout (timeout),
    .bus_err (bus_err)
  );
`else
  assign timeout = 1'b0;
  // The watchdog limit is meaningless here; folding it in keeps the port list uniform
  assign bus_err = 1'b0 && (TIMEOUT_CYC != 0);
`endif

endmodule

// File: doc/fetch_mem_if.md
Name: fetch_mem_if

Overview:
- Instruction-fetch and memory-interface stage directly below the multicycle controller.
- Owns PC and the two-word instruction register (IR); supplies `upcode` and the operand address back to the controller and datapath.
- Turns the controller's one-cycle memRead/memWrite strobes into a req/ack transaction on a variable-latency memory bus.
- Exposes `busy` so the controller can hold its state while a transfer is outstanding.

Parameters:
- ADDR_W, 12, memory address and PC width.
- WORD_W, 8, memory word width. IR word0 is {upcode[3:0], page[3:0]}; IR word1 is low address [7:0].
- TIMEOUT_CYC, 255, ack watchdog limit in cycles; used only with the optional feature.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- pcWrite  in  1  increment PC when the accepted read completes.
- irWrite  in  1  load the read word into IR when the read completes.
- IRwriteSel  in  1  0 = load IR word0, 1 = load IR word1.
- memAddressSel  in  1  0 = address from PC, 1 = address from operand_addr.
- memRead  in  1  start a read transaction.
- memWrite  in  1  start a write transaction.
- ac_data  in  WORD_W  write data from the accumulator.
- mem_req  out  1  bus request, held until ack.
- mem_we  out  1  1 = write transaction.
- mem_addr  out  ADDR_W  bus address.
- mem_wdata  out  WORD_W  bus write data.
- mem_rdata  in  WORD_W  bus read data, valid with mem_ack.
- mem_ack  in  1  bus completion, sampled only while mem_req=1.
- upcode  out  4  IR word0[7:4].
- operand_addr  out  ADDR_W  {IR word0[3:0], IR word1}, zero-extended or truncated to ADDR_W.
- pc  out  ADDR_W  current PC.
- rd_data  out  WORD_W  last read word, for the AC datapath.
- rd_valid  out  1  one-cycle pulse when rd_data updates.
- busy  out  1  transaction accepted and not yet completed.
- bus_err  out  1  sticky timeout flag; tied 0 without the feature.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, including pc, IR, rd_data and mem_req; FSM goes to IDLE.
- FSM states are IDLE, REQ, ABORT.
  - ABORT exists only with the optional feature.
- IDLE, with memRead or memWrite high at a clock edge:
  - Latch the command: we = memWrite, address by memAddressSel, ac_data, pcWrite, irWrite, IRwriteSel.
  - Go to REQ; busy=1 from the next cycle.
- Simultaneous memRead and memWrite: write wins and the read is dropped.
- Commands are ignored while busy=1; they are not queued.
- REQ:
  - mem_req=1; mem_addr, mem_we and mem_wdata are held stable from the latched values.
  - On an edge with mem_ack=1, the transaction completes and the FSM returns to IDLE, so mem_req=0 and busy=0 next cycle.
- Completion of a read:
  - rd_data <= mem_rdata and rd_valid pulses for one cycle.
  - If the latched irWrite=1, IR word[latched IRwriteSel] <= mem_rdata.
  - If the latched pcWrite=1, pc <= pc+1, wrapping modulo 2^ADDR_W (max to 0).
- Completion of a write: no change to pc, IR or rd_data.
- Latency:
  - Command at edge E0 gives mem_req=1 during the cycle after E0.
  - Ack at edge E1 makes the results visible after E1.
  - Minimum is 2 edges from command to result.
- upcode and operand_addr are continuous functions of IR.
  - A new IR value is visible in the cycle after the completing edge.
  - It is stable for the controller's next decode.
- mem_ack while not in REQ is ignored.
- Reset mid-transaction drops mem_req immediately and discards the transaction.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- With the macro defined:
  - A cycle counter runs in REQ and clears on every command acceptance.
  - If it reaches TIMEOUT_CYC with no ack, go to ABORT for one cycle: mem_req=0, no state update, bus_err <= 1 (sticky until reset), then IDLE.
- Without the macro: REQ waits forever and bus_err is tied to 0.

Decomposition:
- Shared package ac_cpu_pkg holds:
  - opcode constants OP_LDA=3'b000, OP_STA=3'b001, OP_ADA=3'b010 and OP_ANA=3'b011, all on upcode[3:1];
  - default ADDR_W and WORD_W;
  - the fetch FSM state encoding.
- One sub-module, fetch_watchdog (counter, compare and sticky flag), instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Reset: rst low mid-REQ with mem_req=1 -> mem_req, pc, upcode, busy and bus_err are 0 immediately; no update after release.
- Fetch pair: pc=0x000, memRead+irWrite+pcWrite, IRwriteSel=0, ack rdata=0x45 at 1 cycle; then IRwriteSel=1, rdata=0x3C -> upcode=4, operand_addr=0x53C, pc=0x002, rd_valid pulsed twice.
- Operand read with 3-cycle ack latency: memAddressSel=1, rdata=0xA7 -> mem_addr=0x53C held for 3 cycles, rd_data=0xA7, pc unchanged, busy high exactly 3 cycles.
- Write, and read+write together: ac_data=0x99 with both strobes high -> mem_we=1, mem_wdata=0x99, rd_valid never pulses.
- Wrap and ignore: pc=0xFFF, fetch with pcWrite -> pc=0x000; a memRead pulse while busy produces no second mem_req.
- FETCH_TIMEOUT_EN with TIMEOUT_CYC=4 and no ack -> mem_req drops after 4 cycles, bus_err=1 and stays 1, the next command is accepted.
